// File: rtl/uart_dec_rx.sv
`default_nettype none
// ============================================================================
// Module   : uart_dec_rx
// Brief    : 8N1 UART receiver feeding a signed 5-digit BCD message parser
//            ("+ddddd" / "-ddddd" terminated by CR or LF).
// Revision : 1.0 - initial release
// ============================================================================
module uart_dec_rx #(
    parameter int CLK_FREQ = 50000000,
    parameter int BAUD     = 115200
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx_pin,
    output logic [19:0] dec,
    output logic        sign,
    output logic        dec_valid,
    output logic [7:0]  rx_byte,
    output logic        rx_byte_vld,
    output logic        rx_err
);

    localparam int c_DIV   = CLK_FREQ / BAUD;
    localparam int c_HALF  = c_DIV / 2;
    localparam int c_CNT_W = (c_DIV > 1) ? $clog2(c_DIV) : 1;

    localparam logic [c_CNT_W-1:0] c_DIV_LAST  = c_CNT_W'(c_DIV - 1);
    localparam logic [c_CNT_W-1:0] c_HALF_LAST = c_CNT_W'(c_HALF - 1);

    localparam logic [7:0] c_PLUS  = 8'h2B;
    localparam logic [7:0] c_MINUS = 8'h2D;
    localparam logic [7:0] c_CR    = 8'h0D;
    localparam logic [7:0] c_LF    = 8'h0A;
    localparam logic [7:0] c_ZERO  = 8'h30;
    localparam logic [7:0] c_NINE  = 8'h39;

    typedef enum logic [1:0] {
        B_IDLE  = 2'd0,
        B_START = 2'd1,
        B_DATA  = 2'd2,
        B_STOP  = 2'd3
    } bit_state_t;

    typedef enum logic [1:0] {
        M_SIGN = 2'd0,
        M_DIG  = 2'd1,
        M_TERM = 2'd2
    } msg_state_t;

    // ------------------------------------------------------------------
    // Bit-level receiver
    // ------------------------------------------------------------------
    logic               r_sync1;
    logic               r_sync2;
    logic               r_rx_prev;
    logic               r_armed;
    bit_state_t         r_bstate;
    bit_state_t         w_bnext;
    logic [c_CNT_W-1:0] r_cnt;
    logic [c_CNT_W-1:0] w_cnt_next;
    logic [7:0]         r_shift;
    logic [7:0]         w_shift_next;
    logic [2:0]         r_bit_idx;
    logic [2:0]         w_bit_idx_next;
    logic               w_armed_next;
    logic               w_byte_done;
    logic               w_frame_err;

    always_comb begin
        w_bnext        = r_bstate;
        w_cnt_next     = r_cnt + 1'b1;
        w_shift_next   = r_shift;
        w_bit_idx_next = r_bit_idx;
        w_armed_next   = r_armed | r_sync2;
        w_byte_done    = 1'b0;
        w_frame_err    = 1'b0;

        case (r_bstate)
            B_IDLE: begin
                w_cnt_next = '0;
                if (r_armed && r_rx_prev && !r_sync2) begin
                    w_bnext = B_START;
                end
            end
            B_START: begin
                if (r_cnt == c_HALF_LAST) begin
                    w_cnt_next = '0;
                    if (!r_sync2) begin
                        w_bnext        = B_DATA;
                        w_bit_idx_next = '0;
                    end else begin
                        w_bnext = B_IDLE;
                    end
                end
            end
            B_DATA: begin
                if (r_cnt == c_DIV_LAST) begin
                    w_cnt_next     = '0;
                    w_shift_next   = {r_sync2, r_shift[7:1]};
                    w_bit_idx_next = r_bit_idx + 3'd1;
                    if (r_bit_idx == 3'd7) begin
                        w_bnext = B_STOP;
                    end
                end
            end
            B_STOP: begin
                if (r_cnt == c_DIV_LAST) begin
                    w_cnt_next = '0;
                    w_bnext    = B_IDLE;
                    if (r_sync2) begin
                        w_byte_done = 1'b1;
                    end else begin
                        // Line still low: wait for it to go high before a new start edge counts.
                        w_frame_err  = 1'b1;
                        w_armed_next = 1'b0;
                    end
                end
            end
            default: begin
                w_bnext    = B_IDLE;
                w_cnt_next = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1     <= 1'b1;
            r_sync2     <= 1'b1;
            r_rx_prev   <= 1'b1;
            r_armed     <= 1'b1;
            r_bstate    <= B_IDLE;
            r_cnt       <= '0;
            r_shift     <= '0;
            r_bit_idx   <= '0;
            rx_byte     <= '0;
            rx_byte_vld <= 1'b0;
        end else begin
            r_sync1     <= rx_pin;
            r_sync2     <= r_sync1;
            r_rx_prev   <= r_sync2;
            r_armed     <= w_armed_next;
            r_bstate    <= w_bnext;
            r_cnt       <= w_cnt_next;
            r_shift     <= w_shift_next;
            r_bit_idx   <= w_bit_idx_next;
            rx_byte_vld <= w_byte_done;
            if (w_byte_done) begin
                rx_byte <= r_shift;
            end
        end
    end

    // ------------------------------------------------------------------
    // Message parser, driven by the registered byte strobe
    // ------------------------------------------------------------------
    msg_state_t  r_mstate;
    msg_state_t  w_mnext;
    logic [19:0] r_dec_tmp;
    logic [19:0] w_dec_tmp_next;
    logic        r_sign_tmp;
    logic        w_sign_tmp_next;
    logic [2:0]  r_dcnt;
    logic [2:0]  w_dcnt_next;
    logic        w_fmt_err;
    logic        w_accept;
    logic        w_is_digit;

    // ASCII '0'..'9' carry their value in the low nibble.
    assign w_is_digit = (rx_byte >= c_ZERO) && (rx_byte <= c_NINE);

    always_comb begin
        w_mnext         = r_mstate;
        w_dec_tmp_next  = r_dec_tmp;
        w_sign_tmp_next = r_sign_tmp;
        w_dcnt_next     = r_dcnt;
        w_fmt_err       = 1'b0;
        w_accept        = 1'b0;

        if (w_frame_err) begin
            w_mnext = M_SIGN;
        end else if (rx_byte_vld) begin
            case (r_mstate)
                M_SIGN: begin
                    if ((rx_byte == c_PLUS) || (rx_byte == c_MINUS)) begin
                        w_sign_tmp_next = (rx_byte == c_MINUS);
                        w_dcnt_next     = '0;
                        w_dec_tmp_next  = '0;
                        w_mnext         = M_DIG;
                    end
                end
                M_DIG: begin
                    if (w_is_digit) begin
                        w_dec_tmp_next = {r_dec_tmp[15:0], rx_byte[3:0]};
                        w_dcnt_next    = r_dcnt + 3'd1;
                        if (r_dcnt == 3'd4) begin
                            w_mnext = M_TERM;
                        end
                    end else begin
                        w_fmt_err = 1'b1;
                        w_mnext   = M_SIGN;
                    end
                end
                M_TERM: begin
                    w_mnext = M_SIGN;
                    if ((rx_byte == c_CR) || (rx_byte == c_LF)) begin
                        w_accept = 1'b1;
                    end else begin
                        w_fmt_err = 1'b1;
                    end
                end
                default: begin
                    w_mnext = M_SIGN;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mstate   <= M_SIGN;
            r_dec_tmp  <= '0;
            r_sign_tmp <= 1'b0;
            r_dcnt     <= '0;
            dec        <= '0;
            sign       <= 1'b0;
            dec_valid  <= 1'b0;
            rx_err     <= 1'b0;
        end else begin
            r_mstate   <= w_mnext;
            r_dec_tmp  <= w_dec_tmp_next;
            r_sign_tmp <= w_sign_tmp_next;
            r_dcnt     <= w_dcnt_next;
            dec_valid  <= w_accept;
            rx_err     <= w_frame_err | w_fmt_err;
            if (w_accept) begin
                dec  <= r_dec_tmp;
                sign <= r_sign_tmp;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_dec_rx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_uart_dec_rx
// Brief    : Self-checking bench: serial driver, event-queue message model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_dec_rx;

    // 32 clocks per bit keeps the run short while preserving mid-bit sampling.
    localparam int  CLK_FREQ = 3686400;
    localparam int  BAUD     = 115200;
    localparam int  DIV      = CLK_FREQ / BAUD;
    localparam real CLK_NS   = 20.0;
    localparam real BIT_NS   = DIV * CLK_NS;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rx_pin = 1'b1;
    logic [19:0] dec;
    logic        sign;
    logic        dec_valid;
    logic [7:0]  rx_byte;
    logic        rx_byte_vld;
    logic        rx_err;

    uart_dec_rx #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) dut (
        .clk        (clk),
        .rst        (rst),
        .rx_pin     (rx_pin),
        .dec        (dec),
        .sign       (sign),
        .dec_valid  (dec_valid),
        .rx_byte    (rx_byte),
        .rx_byte_vld(rx_byte_vld),
        .rx_err     (rx_err)
    );

    always #(CLK_NS / 2.0) clk = ~clk;

    typedef enum int {K_BYTE, K_ERR, K_VALID} kind_t;
    typedef struct {
        kind_t       kind;
        logic [7:0]  b;
        logic [19:0] d;
        logic        s;
    } ev_t;

    ev_t         exp_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          cnt_byte = 0;
    int          cnt_err  = 0;
    int          cnt_valid = 0;
    logic [19:0] shown_dec  = '0;
    logic        shown_sign = 1'b0;
    logic        prev_vld   = 1'b0;

    int          m_phase = 0;
    int          m_val   = 0;
    logic        m_sign  = 1'b0;
    logic [19:0] m_acc_dec  = '0;
    logic        m_acc_sign = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [19:0] to_bcd(input int v);
        return {4'(v / 10000 % 10), 4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
    endfunction

    function automatic ev_t mk(input kind_t k, input logic [7:0] b, input logic [19:0] d, input logic s);
        ev_t e;
        e.kind = k; e.b = b; e.d = d; e.s = s;
        return e;
    endfunction

    // Message model: phase counts characters of the current "+ddddd<term>" candidate.
    task automatic model_byte(input logic [7:0] b, input bit framed);
        if (!framed) begin
            exp_q.push_back(mk(K_ERR, 8'h00, 20'h0, 1'b0));
            m_phase = 0;
            return;
        end
        exp_q.push_back(mk(K_BYTE, b, 20'h0, 1'b0));
        if (m_phase == 0) begin
            if (b == 8'h2B || b == 8'h2D) begin
                m_sign  = (b == 8'h2D);
                m_val   = 0;
                m_phase = 1;
            end
        end else if (m_phase <= 5) begin
            if (b >= 8'h30 && b <= 8'h39) begin
                m_val = m_val * 10 + int'(b) - 48;
                m_phase++;
            end else begin
                exp_q.push_back(mk(K_ERR, 8'h00, 20'h0, 1'b0));
                m_phase = 0;
            end
        end else begin
            if (b == 8'h0D || b == 8'h0A) begin
                m_acc_dec  = to_bcd(m_val);
                m_acc_sign = m_sign;
                exp_q.push_back(mk(K_VALID, 8'h00, m_acc_dec, m_acc_sign));
            end else begin
                exp_q.push_back(mk(K_ERR, 8'h00, 20'h0, 1'b0));
            end
            m_phase = 0;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit stop_ok, input real scale);
        real t;
        t = BIT_NS * scale;
        model_byte(b, stop_ok);
        rx_pin = 1'b0;
        #(t);
        for (int i = 0; i < 8; i++) begin
            rx_pin = b[i];
            #(t);
        end
        rx_pin = stop_ok;
        #(t);
        rx_pin = 1'b1;
        #(t * 0.25);
    endtask

    task automatic send_str(input string s, input real scale);
        for (int i = 0; i < s.len(); i++) begin
            send_byte(s[i], 1'b1, scale);
        end
    endtask

    task automatic settle();
        repeat (3 * DIV) @(posedge clk);
    endtask

    // Compare process: every pulse must match the head of the expected-event queue.
    always @(negedge clk) begin
        ev_t   e;
        kind_t k;
        if (rst) begin
            check("reset_state", {6'd0, dec, sign, dec_valid, rx_byte_vld, rx_err, rx_byte != 8'h00}, 32'h0);
            shown_dec  = '0;
            shown_sign = 1'b0;
            prev_vld   = 1'b0;
        end else begin
            if (rx_err && dec_valid) begin
                check("err_and_valid_together", 32'd1, 32'd0);
            end
            if (rx_byte_vld || rx_err || dec_valid) begin
                k = rx_byte_vld ? K_BYTE : (rx_err ? K_ERR : K_VALID);
                if (rx_byte_vld) cnt_byte++;
                if (rx_err) cnt_err++;
                if (dec_valid) cnt_valid++;
                if (exp_q.size() == 0) begin
                    check("unexpected_pulse_kind", 32'(k), 32'hFF);
                end else begin
                    e = exp_q.pop_front();
                    check("pulse_kind", 32'(k), 32'(e.kind));
                    if (k == K_BYTE && e.kind == K_BYTE) begin
                        check("rx_byte", 32'(rx_byte), 32'(e.b));
                    end
                    if (k == K_VALID && e.kind == K_VALID) begin
                        shown_dec  = e.d;
                        shown_sign = e.s;
                        check("valid_follows_byte", 32'(prev_vld), 32'd1);
                    end
                end
            end
            check("dec_hold", 32'(dec), 32'(shown_dec));
            check("sign_hold", 32'(sign), 32'(shown_sign));
            prev_vld = rx_byte_vld;
        end
    end

    initial begin
        int          b0, e0, v0;
        logic [7:0]  msg[7];
        real         sc;
        int          cpos;

        rx_pin = 1'b1;
        rst    = 1'b1;
        repeat (5) @(posedge clk);
        #3 rst = 1'b0;
        repeat (DIV) @(posedge clk);

        // Negative five-digit message
        b0 = cnt_byte; e0 = cnt_err; v0 = cnt_valid;
        send_str("-65535\r", 1.0);
        settle();
        check("m1_dec", 32'(dec), 32'h65535);
        check("m1_sign", 32'(sign), 32'd1);
        check("m1_bytes", cnt_byte - b0, 7);
        check("m1_valids", cnt_valid - v0, 1);
        check("m1_errs", cnt_err - e0, 0);

        // Accepted message, then a rejected one that must not disturb outputs
        send_str("+01234\n", 1.0);
        settle();
        check("m2_dec", 32'(dec), 32'h01234);
        check("m2_sign", 32'(sign), 32'd0);
        e0 = cnt_err;
        send_str("-9", 1.0);
        send_byte(8'h41, 1'b1, 1.0);
        settle();
        check("m3_errs", cnt_err - e0, 1);
        check("m3_dec", 32'(dec), 32'h01234);
        check("m3_sign", 32'(sign), 32'd0);

        // Framing error, then recovery
        b0 = cnt_byte; e0 = cnt_err;
        send_byte(8'h55, 1'b0, 1.0);
        settle();
        check("frame_err_pulse", cnt_err - e0, 1);
        check("frame_err_nobyte", cnt_byte - b0, 0);
        send_str("+00007\r", 1.0);
        settle();
        check("m4_dec", 32'(dec), 32'h00007);

        // Short low glitch on an idle line
        b0 = cnt_byte; e0 = cnt_err;
        @(posedge clk);
        rx_pin = 1'b0;
        #100;
        rx_pin = 1'b1;
        settle();
        check("glitch_bytes", cnt_byte - b0, 0);
        check("glitch_errs", cnt_err - e0, 0);
        send_str("+00890\r", 1.0);
        settle();
        check("m5_dec", 32'(dec), 32'h00890);

        // Reset in the middle of a byte and of a message
        send_str("+123", 1.0);
        rx_pin = 1'b0;
        #(BIT_NS);
        rx_pin = 1'b1;
        #(BIT_NS * 1.5);
        @(posedge clk);
        #3 rst = 1'b1;
        m_phase    = 0;
        m_acc_dec  = '0;
        m_acc_sign = 1'b0;
        repeat (3) @(posedge clk);
        #3 rst = 1'b0;
        settle();
        check("post_reset_dec", 32'(dec), 32'h0);
        v0 = cnt_valid;
        send_str("+45678\r", 1.0);
        settle();
        check("m6_dec", 32'(dec), 32'h45678);
        check("m6_sign", 32'(sign), 32'd0);
        check("m6_valids", cnt_valid - v0, 1);

        // Too many digits, plus baud mismatch in both directions
        e0 = cnt_err;
        send_str("+123456\r", 1.02);
        settle();
        check("m7_errs", cnt_err - e0, 1);
        check("m7_dec", 32'(dec), 32'h45678);
        send_str("-98765\r", 0.98);
        settle();
        check("m8_dec", 32'(dec), 32'h98765);
        check("m8_sign", 32'(sign), 32'd1);

        // Randomized messages with occasional corruption and baud skew
        for (int m = 0; m < 6; m++) begin
            sc = 0.98 + 0.04 * real'($urandom_range(100, 0)) / 100.0;
            msg[0] = ($urandom_range(1, 0) != 0) ? 8'h2D : 8'h2B;
            for (int k = 1; k < 6; k++) begin
                msg[k] = 8'h30 + 8'($urandom_range(9, 0));
            end
            msg[6] = ($urandom_range(1, 0) != 0) ? 8'h0D : 8'h0A;
            if ($urandom_range(2, 0) == 0) begin
                cpos = int'($urandom_range(6, 0));
                msg[cpos] = 8'($urandom_range(126, 32));
            end
            for (int k = 0; k < 7; k++) begin
                send_byte(msg[k], 1'b1, sc);
            end
            settle();
            check("rand_dec", 32'(dec), 32'(m_acc_dec));
            check("rand_sign", 32'(sign), 32'(m_acc_sign));
        end

        settle();
        check("pending_events", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
